// File: rtl/aspiradora_cmd_encoder_if.sv
// rtl/aspiradora_cmd_encoder_if.sv - switch inputs and command outputs of the vacuum-cleaner command encoder
interface aspiradora_cmd_encoder_if;
  logic [3:0] SW;
  logic       power_off;
  logic       on;
  logic       cleaning;
  logic       evading;
  logic       cmd_active;
  logic [1:0] cmd_code;
  logic       cmd_strobe;
  logic [3:0] sw_db;

  // Board/bench side: drives the raw switches, observes the commands.
  modport master (
    output SW,
    input  power_off,
    input  on,
    input  cleaning,
    input  evading,
    input  cmd_active,
    input  cmd_code,
    input  cmd_strobe,
    input  sw_db
  );

  // Encoder side: reads the raw switches, drives the commands.
  modport slave (
    input  SW,
    output power_off,
    output on,
    output cleaning,
    output evading,
    output cmd_active,
    output cmd_code,
    output cmd_strobe,
    output sw_db
  );
endinterface

// File: rtl/aspiradora_cmd_encoder.sv
// rtl/aspiradora_cmd_encoder.sv - synchronise, debounce and prioritise the four vacuum-cleaner switches
module aspiradora_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       CLK100MHZ,
  input  logic                       rst,
  aspiradora_cmd_encoder_if.slave    bus
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  // Synchroniser chain, one 4-bit word per stage; the last stage is the clean sample.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  s;

  // Per-switch debounce machine.
  db_state_e                   state_q [4];
  db_state_e                   state_d [4];
  logic [3:0][CW-1:0]          cnt_q, cnt_d;
  logic [3:0]                  sw_db_q, sw_db_d;

  // Registered prioritised outputs. cmd bit order: {evading, cleaning, on, power_off}.
  logic [3:0]                  cmd_q, cmd_d;
  logic [1:0]                  code_q, code_d;
  logic                        active_q, active_d;
  logic                        strobe_q, strobe_d;

  // Shift the raw switches through the synchroniser.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.SW;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce each switch independently: count consecutive mismatching edges, accept on the last one.
  always_comb begin
    sw_db_d = sw_db_q;
    cnt_d   = cnt_q;
    for (int b = 0; b < 4; b++) begin
      state_d[b] = state_q[b];
      case (state_q[b])
        ST_STABLE: begin
          cnt_d[b] = '0;
          if (s[b] != sw_db_q[b]) begin
            if (CNT_LAST == '0) begin
              // Single-cycle debounce accepts on the first mismatching edge.
              sw_db_d[b] = s[b];
            end else begin
              cnt_d[b]   = CW'(1);
              state_d[b] = ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          if (s[b] == sw_db_q[b]) begin
            // Bounce: the level came back before the count completed.
            cnt_d[b]   = '0;
            state_d[b] = ST_STABLE;
          end else if (cnt_q[b] == CNT_LAST) begin
            sw_db_d[b] = s[b];
            cnt_d[b]   = '0;
            state_d[b] = ST_STABLE;
          end else begin
            cnt_d[b]   = cnt_q[b] + CW'(1);
          end
        end
        default: begin
          cnt_d[b]   = '0;
          state_d[b] = ST_STABLE;
        end
      endcase
    end
  end

  // Fixed priority power_off > evading > cleaning > on, plus change detection for the strobe.
  always_comb begin
    cmd_d    = 4'b0000;
    code_d   = 2'd0;
    active_d = |sw_db_q;
    if (sw_db_q[0]) begin
      cmd_d  = 4'b0001;
      code_d = 2'd0;
    end else if (sw_db_q[3]) begin
      cmd_d  = 4'b1000;
      code_d = 2'd3;
    end else if (sw_db_q[2]) begin
      cmd_d  = 4'b0100;
      code_d = 2'd2;
    end else if (sw_db_q[1]) begin
      cmd_d  = 4'b0010;
      code_d = 2'd1;
    end
    // Masked lower-priority changes leave {active, code} unchanged, so they raise no strobe.
    strobe_d = ({active_d, code_d} != {active_q, code_q});
  end

  // All state of the block, cleared together by the synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      sw_db_q  <= 4'b0000;
      cmd_q    <= 4'b0000;
      code_q   <= 2'd0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        state_q[b] <= ST_STABLE;
      end
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      sw_db_q  <= sw_db_d;
      cmd_q    <= cmd_d;
      code_q   <= code_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
      for (int b = 0; b < 4; b++) begin
        state_q[b] <= state_d[b];
      end
    end
  end

  assign bus.power_off  = cmd_q[0];
  assign bus.on         = cmd_q[1];
  assign bus.cleaning   = cmd_q[2];
  assign bus.evading    = cmd_q[3];
  assign bus.cmd_active = active_q;
  assign bus.cmd_code   = code_q;
  assign bus.cmd_strobe = strobe_q;
  assign bus.sw_db      = sw_db_q;

endmodule

// File: tb/tb_aspiradora_cmd_encoder.sv
// tb/tb_aspiradora_cmd_encoder.sv - directed self-checking bench for aspiradora_cmd_encoder
module tb_aspiradora_cmd_encoder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  aspiradora_cmd_encoder_if bus ();

  aspiradora_cmd_encoder #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // One rising edge, then sample 1 ns later; count strobes seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.cmd_strobe) strobe_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {evading, cleaning, on, power_off}
  function automatic logic [3:0] cmds();
    return {bus.evading, bus.cleaning, bus.on, bus.power_off};
  endfunction

  task automatic check_out(input string tag, input logic [3:0] exp_cmd,
                           input logic exp_act, input logic [1:0] exp_code);
    check({tag, "_cmd"},    {28'd0, cmds()},          {28'd0, exp_cmd});
    check({tag, "_active"}, {31'd0, bus.cmd_active},  {31'd0, exp_act});
    check({tag, "_code"},   {30'd0, bus.cmd_code},    {30'd0, exp_code});
  endtask

  initial begin
    rst    = 1'b1;
    bus.SW = 4'b0000;

    // Reset state after the first reset edge.
    tick();
    check_out("reset", 4'b0000, 1'b0, 2'd0);
    check("reset_strobe", {31'd0, bus.cmd_strobe}, 32'd0);
    check("reset_swdb",   {28'd0, bus.sw_db},      32'd0);
    tick();
    rst = 1'b0;

    // Idle switches: nothing happens.
    strobe_cnt = 0;
    ticks(10);
    check_out("idle", 4'b0000, 1'b0, 2'd0);
    check("idle_strobes", strobe_cnt, 32'd0);

    // SW[1] rises: 'on' appears after edge 6 with one strobe.
    strobe_cnt = 0;
    bus.SW = 4'b0010;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("on_lat_e%0d", e), {31'd0, bus.on}, 32'd0);
    end
    tick();
    check_out("on_e6", 4'b0010, 1'b1, 2'd1);
    check("on_e6_strobe", {31'd0, bus.cmd_strobe}, 32'd1);
    tick();
    check("on_e7_strobe", {31'd0, bus.cmd_strobe}, 32'd0);
    check("on_strobes", strobe_cnt, 32'd1);

    // SW[2] bounces 3 high / 1 low: never accepted.
    strobe_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      bus.SW = 4'b0110;
      ticks(3);
      bus.SW = 4'b0010;
      tick();
    end
    ticks(8);
    check("bounce_swdb", {28'd0, bus.sw_db}, 32'h2);
    check_out("bounce", 4'b0010, 1'b1, 2'd1);
    check("bounce_strobes", strobe_cnt, 32'd0);

    // Stable cleaning, then evading, then power_off.
    strobe_cnt = 0;
    bus.SW = 4'b0110;
    ticks(8);
    check_out("clean", 4'b0100, 1'b1, 2'd2);
    check("clean_strobes", strobe_cnt, 32'd1);
    strobe_cnt = 0;
    bus.SW = 4'b1110;
    ticks(8);
    check_out("evade", 4'b1000, 1'b1, 2'd3);
    check("evade_strobes", strobe_cnt, 32'd1);
    strobe_cnt = 0;
    bus.SW = 4'b1111;
    ticks(8);
    check_out("poff", 4'b0001, 1'b1, 2'd0);
    check("poff_strobes", strobe_cnt, 32'd1);

    // Masked changes under power_off: sw_db follows, outputs and strobe do not.
    strobe_cnt = 0;
    bus.SW = 4'b1001;
    ticks(8);
    check("mask1_swdb", {28'd0, bus.sw_db}, 32'h9);
    check_out("mask1", 4'b0001, 1'b1, 2'd0);
    bus.SW = 4'b1101;
    ticks(8);
    check("mask2_swdb", {28'd0, bus.sw_db}, 32'hD);
    check_out("mask2", 4'b0001, 1'b1, 2'd0);
    check("mask_strobes", strobe_cnt, 32'd0);

    // All switches released: going inactive strobes once.
    strobe_cnt = 0;
    bus.SW = 4'b0000;
    ticks(8);
    check_out("inactive", 4'b0000, 1'b0, 2'd0);
    check("inactive_strobes", strobe_cnt, 32'd1);

    // Re-activate 'on', start a pending change, then reset mid-count.
    bus.SW = 4'b0010;
    ticks(8);
    check_out("pre_rst", 4'b0010, 1'b1, 2'd1);
    bus.SW = 4'b0110;
    ticks(3);
    bus.SW = 4'b0010;
    rst = 1'b1;
    tick();
    check_out("mid_rst", 4'b0000, 1'b0, 2'd0);
    check("mid_rst_swdb",   {28'd0, bus.sw_db},      32'd0);
    check("mid_rst_strobe", {31'd0, bus.cmd_strobe}, 32'd0);
    rst = 1'b0;
    strobe_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("post_rst_e%0d", e), {31'd0, bus.on}, 32'd0);
    end
    tick();
    check_out("post_rst_e6", 4'b0010, 1'b1, 2'd1);
    check("post_rst_strobe", {31'd0, bus.cmd_strobe}, 32'd1);
    ticks(3);
    check("post_rst_strobes", strobe_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aspiradora_cmd_encoder.md
Name: aspiradora_cmd_encoder

Overview:
Command-side front end for the vacuum-cleaner Moore FSM. It takes the four raw board switches, synchronises and debounces each one, and resolves simultaneous requests by fixed priority. It then drives the FSM's command inputs (power_off, on, cleaning, evading) as clean, mutually exclusive levels. It sits between the switch pins and the FSM in the top level, and also exports an encoded command and a change strobe for LEDs and debug.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a switch change is accepted (10 ms at 100 MHz); legal range >= 1
SYNC_STAGES, 2, depth of the per-switch synchroniser chain; legal range >= 2

Ports:
CLK100MHZ  input  1  system clock, 100 MHz; the block's only clock
rst  input  1  synchronous, active-high reset
SW  input  4  raw asynchronous switches: SW[0]=power_off, SW[1]=on, SW[2]=cleaning, SW[3]=evading
power_off  output  1  debounced, prioritised power-off command level to the FSM
on  output  1  debounced, prioritised on command level to the FSM
cleaning  output  1  debounced, prioritised cleaning command level to the FSM
evading  output  1  debounced, prioritised evading command level to the FSM
cmd_active  output  1  high while any command output is high
cmd_code  output  2  encoded active command: 0 power_off, 1 on, 2 cleaning, 3 evading; 0 when cmd_active=0
cmd_strobe  output  1  one-cycle pulse when the selected command changes
sw_db  output  4  debounced switch levels before prioritisation, for debug

Behaviour:
- Clock and reset: a single clock domain, CLK100MHZ. rst is synchronous and active-high.
- Reset values: every output, synchroniser flop, debounced level and counter is 0 at the first rising edge with rst=1. A reset mid-debounce discards partial counts.
- Synchroniser: each SW bit passes through SYNC_STAGES flops. The last stage is "s".
- Debounce, per bit, two-state machine:
  - STABLE: counter = 0 while s == sw_db.
  - PENDING: entered when s != sw_db. The counter increments on each edge where s != sw_db.
  - Bounce: if s returns to sw_db before the count completes, the counter clears to 0 and the machine returns to STABLE.
  - Accept: on the edge where the count would reach DEBOUNCE_CYCLES, sw_db toggles and the counter clears.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Priority: applied to sw_db as power_off > evading > cleaning > on. Exactly one command output is high, or none when sw_db == 0.
- Output registration: command outputs, cmd_code and cmd_active are registered from sw_db, one cycle after sw_db changes.
- Latency: with SYNC_STAGES=2, a raw level sampled at edge k appears on the command outputs after edge k+DEBOUNCE_CYCLES+2. In general the latency is SYNC_STAGES+DEBOUNCE_CYCLES edges.
- cmd_strobe asserts for exactly one cycle, coincident with the first cycle of new output values, whenever {cmd_active, cmd_code} changes. It covers becoming active, changing command, and going inactive.
- cmd_strobe does not assert on a lower-priority switch change that is masked by a higher-priority active switch, although sw_db still updates.
- Switches are debounced independently. Simultaneous accepts on the same edge are resolved by priority in the same output update, producing a single strobe.
- A switch held high through reset release is seen as a fresh change and is accepted after the full debounce latency.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then hold SW=0000 for 10 cycles -> all outputs 0, cmd_strobe never asserts.
- DEBOUNCE_CYCLES=4. Set SW=0010 at edge 0 -> on=1, cmd_code=1, cmd_active=1 and a single cmd_strobe appear after edge 6; before that, outputs remain 0.
- DEBOUNCE_CYCLES=4. Toggle SW[2] high for 3 cycles, low for 1, repeating for 20 cycles -> sw_db[2] stays 0, cleaning stays 0, no strobe.
- DEBOUNCE_CYCLES=4. SW=0110 stable, then set SW[3]=1 -> outputs move from cleaning to evading (cmd_code 2->3) with one strobe. Then set SW[0]=1 -> power_off=1, cmd_code=0, one strobe.
- With SW=1001 active (power_off selected), toggle SW[2] 0->1 stably -> sw_db[2]=1, outputs unchanged, no strobe.
- Assert rst for 1 cycle mid-PENDING while SW[1]=1 -> all outputs and counters 0 on the next edge. on=1 reappears DEBOUNCE_CYCLES+2 edges after the first post-reset sample.
